ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 8-bit pipelined CPU. Consumes the ID/EX pipeline register outputs (opcode, value, rs/rt/rd, flags, label, memory/regwrite controls) together with register-file read data.
- Performs operand forwarding, ALU/address computation, branch resolution and load-use interlock.
- Registers its results into an EX/MEM pipeline register that drives the memory stage.

Parameters:
- DW, 8, datapath width
- RW, 4, register index width

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_valid_i  in  1  ID/EX slot holds a real instruction
- opcode_i  in  4  opcode from ID/EX
- value_i  in  DW  immediate value
- rs_i, rt_i, rd_i  in  RW each  register indices
- label_flag_i, imm_flag_i, sign_flag_i  in  1 each  decode flags
- label_value_i  in  DW  branch/jump target
- writemem_i, readmem_i, regwrite_i  in  1 each  control bits
- rs_data_i, rt_data_i  in  DW each  register-file read data
- wb_regwrite_i  in  1  MEM/WB writes a register
- wb_rd_i  in  RW  MEM/WB destination
- wb_data_i  in  DW  MEM/WB write data
- stall_o  out  1  hold IF/ID and ID/EX this cycle
- flush_o  out  1  squash IF/ID this cycle
- branch_target_o  out  DW  PC redirect target, valid with flush_o
- halt_o  out  1  core halted
- exm_valid_o  out  1  EX/MEM slot valid
- exm_alu_o  out  DW  ALU result or memory address
- exm_store_data_o  out  DW  forwarded rt value for stores
- exm_rd_o  out  RW  destination index
- exm_writemem_o, exm_readmem_o, exm_regwrite_o  out  1 each  controls to MEM

Behaviour:
- Reset (rst_n=0 at posedge): all registered outputs go to 0, state=RUN. stall_o=0 while reset is asserted.
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, LW=7, SW=8, BEQ=9, BNE=10, JMP=11, SLT=12, MOV=13, NOP=14, HALT=15.
- Effective valid ev = in_valid_i & ~flush_o & ~stall_o & (state==RUN).
- Operand A = fwd(rs). Operand B = value_i if imm_flag_i, else fwd(rt).
- fwd(r) priority:
  - EX/MEM result if exm_valid_o & exm_regwrite_o & ~exm_readmem_o & exm_rd_o==r;
  - else wb_data_i if wb_regwrite_i & wb_rd_i==r;
  - else register-file data.
  - r0 is an ordinary register, with no special case.
- Arithmetic:
  - All results are mod 2^DW.
  - SLL/SRL shift A by B[2:0].
  - SLT gives 1/0: signed compare if sign_flag_i, else unsigned.
  - MOV gives B.
  - LW/SW address = A+B; SW store data = fwd(rt).
  - NOP/HALT/branches: exm_regwrite_o forced 0.
- Latency: 1 cycle. Instruction present in cycle N appears on exm_* at cycle N+1.
- Load-use interlock:
  - stall_o = in_valid_i & exm_valid_o & exm_readmem_o & (exm_rd_o==rs_i | (exm_rd_o==rt_i & (~imm_flag_i | writemem_i))) & state==RUN & ~flush_o.
  - On stall, a bubble is inserted (exm_valid_o=0 next cycle). Upstream holds, and the same instruction is re-presented and then forwarded from WB.
  - The stall is exactly 1 cycle per hazard.
- Branch resolution:
  - BEQ taken if A==B; BNE taken if A!=B; JMP always taken. Resolution applies only when ev=1.
  - Taken is registered: next cycle flush_o=1 for exactly one cycle, with branch_target_o=label_value_i (captured).
  - During the flush cycle this block's own input is squashed.
  - branch_target_o holds its last value otherwise.
- Halt FSM:
  - States: RUN and HALTED. RUN->HALTED on ev & opcode==HALT.
  - In HALTED: halt_o=1, exm_valid_o=0, stall_o=0, flush_o=0, all inputs ignored.
  - Only reset leaves HALTED.
- Simultaneous events:
  - A pending flush overrides stall (stall_o=0 in the flush cycle).
  - A HALT in the slot after a taken branch is squashed.
- Reset mid-operation: clears a pending flush and the EX/MEM contents; no partial outputs survive.
- When ev=0, exm_valid_o=0 and all exm_* control bits=0. Data fields may hold stale values.

Decomposition:
- Package cpu_pkg holds:
  - opcode enum (4-bit) with the values above;
  - DW/RW defaults;
  - exec state enum {RUN, HALTED};
  - an EX/MEM struct type.
- One sub-module, ex_alu: combinational, takes opcode, A, B and sign flag, and returns the result and branch-condition bits. Forwarding, interlock, FSM and registers stay in ex_stage.

Test Plan:
- ADD r3=r1+r2 with rs_data=0x7F, rt_data=0x02 -> exm_alu_o=0x81 next cycle; 0xFF+0x01 -> 0x00 (wrap).
- Back-to-back ADD r3 then SUB r4=r3-r1 -> second uses EX/MEM forwarded value. A simultaneous WB to r3 with a different value loses to EX/MEM.
- LW r5 then ADD r6=r5+r1 -> stall_o=1 for exactly one cycle with one bubble (exm_valid_o=0). The ADD then completes using wb_data_i.
- BEQ with A==B, label 0x40 -> next cycle flush_o=1, branch_target_o=0x40, following instruction squashed. The BNE equivalent is not taken, so no flush.
- SLT 0x80 vs 0x01: sign_flag=1 -> 1, sign_flag=0 -> 0.
- HALT -> halt_o=1 from next cycle and further valid ADDs produce no exm_valid_o. rst_n=0 for one cycle returns to RUN with all outputs 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit pipelined CPU: opcodes, execute-stage state
// and the EX/MEM pipeline register layout.
package cpu_pkg;

   localparam int DW_DEF = 8;
   localparam int RW_DEF = 4;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_LW   = 4'd7,
      OP_SW   = 4'd8,
      OP_BEQ  = 4'd9,
      OP_BNE  = 4'd10,
      OP_JMP  = 4'd11,
      OP_SLT  = 4'd12,
      OP_MOV  = 4'd13,
      OP_NOP  = 4'd14,
      OP_HALT = 4'd15
   } opcode_t;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } execState_t;

   // EX/MEM register contents; field widths follow the default datapath.
   typedef struct packed {
      logic              valid;
      logic [DW_DEF-1:0] alu;
      logic [DW_DEF-1:0] storeData;
      logic [RW_DEF-1:0] rd;
      logic              writemem;
      logic              readmem;
      logic              regwrite;
   } exMem_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU of the execute stage: arithmetic/logic result or
// memory address, plus the operand-equality bit used for branches.
module ex_alu
   import cpu_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic [3:0]    opcode,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          signFlag,
   output logic [DW-1:0] result,
   output logic          equal
);

   opcode_t op;
   logic    lessThan;

   assign op    = opcode_t'(opcode);
   assign equal = (a == b);

   // Result select; SLT compares as signed or unsigned depending on the flag.
   always_comb begin
      result   = '0;
      lessThan = signFlag ? ($signed(a) < $signed(b)) : (a < b);
      case (op)
         OP_ADD:        result = a + b;
         OP_SUB:        result = a - b;
         OP_AND:        result = a & b;
         OP_OR:         result = a | b;
         OP_XOR:        result = a ^ b;
         OP_SLL:        result = a << b[2:0];
         OP_SRL:        result = a >> b[2:0];
         OP_LW, OP_SW:  result = a + b;
         OP_SLT:        result = {{(DW-1){1'b0}}, lessThan};
         OP_MOV:        result = b;
         default:       result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, load-use
// interlock, halt FSM and the EX/MEM pipeline register.
module ex_stage
   import cpu_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid_i,
   input  logic [3:0]    opcode_i,
   input  logic [DW-1:0] value_i,
   input  logic [RW-1:0] rs_i,
   input  logic [RW-1:0] rt_i,
   input  logic [RW-1:0] rd_i,
   input  logic          label_flag_i,
   input  logic          imm_flag_i,
   input  logic          sign_flag_i,
   input  logic [DW-1:0] label_value_i,
   input  logic          writemem_i,
   input  logic          readmem_i,
   input  logic          regwrite_i,
   input  logic [DW-1:0] rs_data_i,
   input  logic [DW-1:0] rt_data_i,
   input  logic          wb_regwrite_i,
   input  logic [RW-1:0] wb_rd_i,
   input  logic [DW-1:0] wb_data_i,
   output logic          stall_o,
   output logic          flush_o,
   output logic [DW-1:0] branch_target_o,
   output logic          halt_o,
   output logic          exm_valid_o,
   output logic [DW-1:0] exm_alu_o,
   output logic [DW-1:0] exm_store_data_o,
   output logic [RW-1:0] exm_rd_o,
   output logic          exm_writemem_o,
   output logic          exm_readmem_o,
   output logic          exm_regwrite_o
);

   execState_t    state, stateNext;
   exMem_t        exm;
   logic          flushPend;
   logic [DW-1:0] targetReg;
   opcode_t       op;
   logic [DW-1:0] fwdRs, fwdRt, opB, aluResult;
   logic          aluEq, ev, evIssue, taken, noWrite, loadHazard;
   logic          unusedLabelFlag;

   // The target is always taken from label_value_i; the decode flag is informational.
   assign unusedLabelFlag = label_flag_i;

   assign op = opcode_t'(opcode_i);

   // Newest producer wins: EX/MEM (non-load), then MEM/WB, then register file.
   function automatic logic [DW-1:0] fwd(input logic [RW-1:0] r, input logic [DW-1:0] rfData,
                                         input exMem_t e, input logic wbWe,
                                         input logic [RW-1:0] wbRd, input logic [DW-1:0] wbData);
      if (e.valid && e.regwrite && !e.readmem && e.rd == r) return e.alu;
      else if (wbWe && wbRd == r)                              return wbData;
      else                                                     return rfData;
   endfunction

   // Operand forwarding and B-operand select.
   always_comb begin
      fwdRs = fwd(rs_i, rs_data_i, exm, wb_regwrite_i, wb_rd_i, wb_data_i);
      fwdRt = fwd(rt_i, rt_data_i, exm, wb_regwrite_i, wb_rd_i, wb_data_i);
      opB   = imm_flag_i ? value_i : fwdRt;
   end

   ex_alu #(.DW(DW)) u_alu (
      .opcode   (opcode_i),
      .a        (fwdRs),
      .b        (opB),
      .signFlag (sign_flag_i),
      .result   (aluResult),
      .equal    (aluEq)
   );

   // A load in EX/MEM feeding rs, or rt when rt is actually read, must wait one cycle.
   assign loadHazard = exm.valid && exm.readmem &&
                       ((exm.rd == rs_i) || ((exm.rd == rt_i) && (!imm_flag_i || writemem_i)));
   assign flush_o    = flushPend && (state == RUN);
   assign stall_o    = rst_n && in_valid_i && loadHazard && (state == RUN) && !flush_o;
   assign ev         = in_valid_i && !flush_o && !stall_o && (state == RUN);
   assign evIssue    = ev && (op != OP_HALT);

   assign branch_target_o  = targetReg;
   assign exm_valid_o      = exm.valid;
   assign exm_alu_o        = exm.alu;
   assign exm_store_data_o = exm.storeData;
   assign exm_rd_o         = exm.rd;
   assign exm_writemem_o   = exm.writemem;
   assign exm_readmem_o    = exm.readmem;
   assign exm_regwrite_o   = exm.regwrite;

   // Branch resolution and register-write suppression by opcode.
   always_comb begin
      taken   = 1'b0;
      noWrite = 1'b0;
      case (op)
         OP_BEQ:           begin taken = ev && aluEq;  noWrite = 1'b1; end
         OP_BNE:           begin taken = ev && !aluEq; noWrite = 1'b1; end
         OP_JMP:           begin taken = ev;           noWrite = 1'b1; end
         OP_NOP, OP_HALT:  noWrite = 1'b1;
         default:          begin taken = 1'b0;         noWrite = 1'b0; end
      endcase
   end

   // Halt FSM next state and halt indication.
   always_comb begin
      stateNext = state;
      halt_o    = (state == HALTED);
      if (state == RUN && ev && op == OP_HALT) stateNext = HALTED;
   end

   // Halt FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= RUN;
      else        state <= stateNext;
   end

   // EX/MEM pipeline register, pending flush and captured branch target.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exm       <= '0;
         flushPend <= 1'b0;
         targetReg <= '0;
      end else begin
         flushPend     <= taken;
         if (taken) targetReg <= label_value_i;
         exm.valid     <= evIssue;
         exm.writemem  <= evIssue && writemem_i;
         exm.readmem   <= evIssue && readmem_i;
         exm.regwrite  <= evIssue && regwrite_i && !noWrite;
         if (ev) begin
            exm.alu       <= aluResult;
            exm.storeData <= fwdRt;
            exm.rd        <= rd_i;
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed steps from the test plan followed by random
// instruction streams, checked against a behavioural model of the stage.
module tb_ex_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid_i;
   logic [3:0] opcode_i;
   logic [7:0] value_i;
   logic [3:0] rs_i, rt_i, rd_i;
   logic       label_flag_i, imm_flag_i, sign_flag_i;
   logic [7:0] label_value_i;
   logic       writemem_i, readmem_i, regwrite_i;
   logic [7:0] rs_data_i, rt_data_i;
   logic       wb_regwrite_i;
   logic [3:0] wb_rd_i;
   logic [7:0] wb_data_i;
   logic       stall_o, flush_o, halt_o;
   logic [7:0] branch_target_o;
   logic       exm_valid_o;
   logic [7:0] exm_alu_o, exm_store_data_o;
   logic [3:0] exm_rd_o;
   logic       exm_writemem_o, exm_readmem_o, exm_regwrite_o;

   int nTests = 0;
   int nFail  = 0;

   // model of architectural EX/MEM contents and stage status
   logic       mKnown = 1'b0;
   logic       mHalted, mFlush, mV, mWm, mRm, mRw;
   logic [7:0] mTarget, mAlu, mSd;
   logic [3:0] mRd;
   logic       obsStall, obsFlush;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .opcode_i(opcode_i),
      .value_i(value_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
      .label_flag_i(label_flag_i), .imm_flag_i(imm_flag_i), .sign_flag_i(sign_flag_i),
      .label_value_i(label_value_i), .writemem_i(writemem_i), .readmem_i(readmem_i),
      .regwrite_i(regwrite_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
      .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .stall_o(stall_o), .flush_o(flush_o), .branch_target_o(branch_target_o),
      .halt_o(halt_o), .exm_valid_o(exm_valid_o), .exm_alu_o(exm_alu_o),
      .exm_store_data_o(exm_store_data_o), .exm_rd_o(exm_rd_o),
      .exm_writemem_o(exm_writemem_o), .exm_readmem_o(exm_readmem_o),
      .exm_regwrite_o(exm_regwrite_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] fwdM(input logic [3:0] r, input logic [7:0] rf);
      if (mV && mRw && !mRm && mRd == r) return mAlu;
      if (wb_regwrite_i && wb_rd_i == r) return wb_data_i;
      return rf;
   endfunction

   function automatic int toSigned(input logic [7:0] v);
      return (int'(v) > 127) ? int'(v) - 256 : int'(v);
   endfunction

   // One clock: check combinational outputs, advance model, check registered outputs.
   task automatic cycle();
      logic [7:0] a, b, r, fRt;
      logic       fl, hz, st, evm, tk, wr;
      #3;
      fl  = mFlush && !mHalted;
      hz  = mV && mRm && (mRd == rs_i || (mRd == rt_i && (!imm_flag_i || writemem_i)));
      st  = rst_n && in_valid_i && hz && !mHalted && !fl;
      evm = in_valid_i && !fl && !st && !mHalted;
      obsStall = stall_o;
      obsFlush = flush_o;
      check("stall", stall_o, st);
      if (mKnown) check("flush", flush_o, fl);
      a   = fwdM(rs_i, rs_data_i);
      fRt = fwdM(rt_i, rt_data_i);
      b   = imm_flag_i ? value_i : fRt;
      case (opcode_i)
         4'd0, 4'd7, 4'd8: r = 8'((int'(a) + int'(b)) % 256);
         4'd1:  r = 8'((int'(a) - int'(b) + 256) % 256);
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = 8'((int'(a) * (1 << (int'(b) % 8))) % 256);
         4'd6:  r = 8'(int'(a) / (1 << (int'(b) % 8)));
         4'd12: r = sign_flag_i ? ((toSigned(a) < toSigned(b)) ? 8'd1 : 8'd0)
                                : ((int'(a) < int'(b)) ? 8'd1 : 8'd0);
         4'd13: r = b;
         default: r = 8'd0;
      endcase
      tk = (opcode_i == 4'd9 && a == b) || (opcode_i == 4'd10 && a != b) || (opcode_i == 4'd11);
      wr = regwrite_i && !(opcode_i inside {4'd9, 4'd10, 4'd11, 4'd14, 4'd15});
      @(posedge clk);
      if (!rst_n) begin
         mHalted = 0; mFlush = 0; mV = 0; mWm = 0; mRm = 0; mRw = 0;
         mTarget = 0; mAlu = 0; mSd = 0; mRd = 0; mKnown = 1;
      end else begin
         mV  = evm && opcode_i != 4'd15;
         mWm = mV && writemem_i;
         mRm = mV && readmem_i;
         mRw = mV && wr;
         if (evm) begin mAlu = r; mSd = fRt; mRd = rd_i; end
         mFlush = evm && tk;
         if (mFlush) mTarget = label_value_i;
         if (evm && opcode_i == 4'd15) mHalted = 1;
      end
      #1;
      check("exm_valid", exm_valid_o, mV);
      check("exm_writemem", exm_writemem_o, mWm);
      check("exm_readmem", exm_readmem_o, mRm);
      check("exm_regwrite", exm_regwrite_o, mRw);
      check("halt", halt_o, mHalted);
      check("target", branch_target_o, mTarget);
      if (mV) begin
         check("exm_alu", exm_alu_o, mAlu);
         check("exm_store", exm_store_data_o, mSd);
         check("exm_rd", exm_rd_o, mRd);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s,
                        input logic [3:0] t, input logic [7:0] sd, input logic [7:0] td);
      in_valid_i = 1; opcode_i = op; rd_i = d; rs_i = s; rt_i = t;
      rs_data_i = sd; rt_data_i = td; value_i = 0; imm_flag_i = 0; sign_flag_i = 0;
      label_flag_i = 0; label_value_i = 0;
      readmem_i  = (op == 4'd7);
      writemem_i = (op == 4'd8);
      regwrite_i = !(op inside {4'd8, 4'd9, 4'd10, 4'd11, 4'd14, 4'd15});
      wb_regwrite_i = 0; wb_rd_i = 0; wb_data_i = 0;
   endtask

   initial begin
      // reset with a live instruction on the inputs
      rst_n = 0;
      issue(4'd0, 4'd3, 4'd1, 4'd2, 8'h11, 8'h22);
      cycle();
      check("rst_valid", exm_valid_o, 1'b0);
      check("rst_alu", exm_alu_o, 8'h00);
      check("rst_store", exm_store_data_o, 8'h00);
      check("rst_rd", exm_rd_o, 4'h0);
      check("rst_flush", flush_o, 1'b0);
      rst_n = 1;

      // ADD and wrap-around
      issue(4'd0, 4'd3, 4'd1, 4'd2, 8'h7F, 8'h02); cycle();
      check("add_7f_02", exm_alu_o, 8'h81);
      issue(4'd0, 4'd3, 4'd1, 4'd2, 8'hFF, 8'h01); cycle();
      check("add_wrap", exm_alu_o, 8'h00);

      // EX/MEM forwarding beats a simultaneous WB to the same register
      issue(4'd0, 4'd3, 4'd1, 4'd2, 8'h10, 8'h20); cycle();
      issue(4'd1, 4'd4, 4'd3, 4'd1, 8'h99, 8'h10);
      wb_regwrite_i = 1; wb_rd_i = 4'd3; wb_data_i = 8'h55;
      cycle();
      check("sub_fwd", exm_alu_o, 8'h20);

      // load-use: one stall, one bubble, then forward from WB
      issue(4'd7, 4'd5, 4'd1, 4'd0, 8'h10, 8'h00);
      imm_flag_i = 1; value_i = 8'h04;
      cycle();
      check("lw_addr", exm_alu_o, 8'h14);
      issue(4'd0, 4'd6, 4'd5, 4'd1, 8'h00, 8'h10); cycle();
      check("lu_stall", obsStall, 1'b1);
      check("lu_bubble", exm_valid_o, 1'b0);
      issue(4'd0, 4'd6, 4'd5, 4'd1, 8'h00, 8'h10);
      wb_regwrite_i = 1; wb_rd_i = 4'd5; wb_data_i = 8'h21;
      cycle();
      check("lu_nostall", obsStall, 1'b0);
      check("lu_result", exm_alu_o, 8'h31);

      // taken BEQ squashes the next slot
      issue(4'd9, 4'd0, 4'd1, 4'd2, 8'h33, 8'h33); label_value_i = 8'h40; cycle();
      issue(4'd0, 4'd7, 4'd1, 4'd2, 8'h01, 8'h02); cycle();
      check("beq_flush", obsFlush, 1'b1);
      check("beq_squash", exm_valid_o, 1'b0);
      check("beq_target", branch_target_o, 8'h40);
      issue(4'd0, 4'd7, 4'd1, 4'd2, 8'h01, 8'h02); cycle();
      check("flush_once", obsFlush, 1'b0);

      // BNE with equal operands is not taken
      issue(4'd10, 4'd0, 4'd1, 4'd2, 8'h33, 8'h33); label_value_i = 8'h80; cycle();
      issue(4'd0, 4'd7, 4'd1, 4'd2, 8'h01, 8'h02); cycle();
      check("bne_noflush", obsFlush, 1'b0);
      check("bne_next_valid", exm_valid_o, 1'b1);
      check("bne_target_held", branch_target_o, 8'h40);

      // SLT signed vs unsigned
      issue(4'd12, 4'd8, 4'd1, 4'd2, 8'h80, 8'h01); sign_flag_i = 1; cycle();
      check("slt_signed", exm_alu_o, 8'h01);
      issue(4'd12, 4'd8, 4'd1, 4'd2, 8'h80, 8'h01); sign_flag_i = 0; cycle();
      check("slt_unsigned", exm_alu_o, 8'h00);

      // HALT then ignored ADDs
      issue(4'd15, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00); cycle();
      check("halt_set", halt_o, 1'b1);
      for (int i = 0; i < 2; i++) begin
         issue(4'd0, 4'd3, 4'd1, 4'd2, 8'h01, 8'h01); cycle();
         check("halt_novalid", exm_valid_o, 1'b0);
      end

      // reset leaves HALTED
      rst_n = 0; cycle();
      check("rst2_halt", halt_o, 1'b0);
      check("rst2_alu", exm_alu_o, 8'h00);
      rst_n = 1;
      issue(4'd4, 4'd2, 4'd1, 4'd2, 8'hF0, 8'h3C); cycle();
      check("xor_after_rst", exm_alu_o, 8'hCC);

      // random instruction streams
      for (int i = 0; i < 600; i++) begin
         rst_n         = ($urandom_range(0, 59) != 0);
         in_valid_i    = ($urandom_range(0, 3) != 0);
         opcode_i      = 4'($urandom_range(0, 14));
         if ($urandom_range(0, 49) == 0) opcode_i = 4'd15;
         rs_i          = 4'($urandom_range(0, 3));
         rt_i          = 4'($urandom_range(0, 3));
         rd_i          = 4'($urandom_range(0, 3));
         value_i       = 8'($urandom);
         imm_flag_i    = 1'($urandom_range(0, 1));
         sign_flag_i   = 1'($urandom_range(0, 1));
         label_flag_i  = 1'($urandom_range(0, 1));
         label_value_i = 8'($urandom);
         readmem_i     = (opcode_i == 4'd7);
         writemem_i    = (opcode_i == 4'd8);
         regwrite_i    = ($urandom_range(0, 3) != 0);
         rs_data_i     = 8'($urandom);
         rt_data_i     = 8'($urandom);
         wb_regwrite_i = 1'($urandom_range(0, 1));
         wb_rd_i       = 4'($urandom_range(0, 3));
         wb_data_i     = 8'($urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
